// File: rtl/vga_pkg.sv
// VGA timing defaults, derived totals and lock FSM encoding,
// shared by the timing generator and the receiver.
package vga_pkg;

    localparam int H_VIS_AREA_PXL    = 800;
    localparam int H_FRONT_PORCH_PXL = 40;
    localparam int H_SYNC_PULSE_PXL  = 128;
    localparam int H_BACK_PORCH_PXL  = 88;
    localparam int V_VIS_AREA_PXL    = 600;
    localparam int V_FRONT_PORCH_PXL = 1;
    localparam int V_SYNC_PULSE_PXL  = 4;
    localparam int V_BACK_PORCH_PXL  = 23;

    function automatic int span_total(
        input int vis,
        input int fp,
        input int sync,
        input int bp
    );
        return vis + fp + sync + bp;
    endfunction

    // Counters restart at the sync leading edge, so the
    // visible region begins after sync plus back porch.
    function automatic int span_start(input int sync, input int bp);
        return sync + bp;
    endfunction

    localparam int H_TOTAL = span_total(H_VIS_AREA_PXL, H_FRONT_PORCH_PXL,
                                        H_SYNC_PULSE_PXL, H_BACK_PORCH_PXL);
    localparam int V_TOTAL = span_total(V_VIS_AREA_PXL, V_FRONT_PORCH_PXL,
                                        V_SYNC_PULSE_PXL, V_BACK_PORCH_PXL);
    localparam int H_START = span_start(H_SYNC_PULSE_PXL, H_BACK_PORCH_PXL);
    localparam int V_START = span_start(V_SYNC_PULSE_PXL, V_BACK_PORCH_PXL);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

endpackage

// File: rtl/vga_sync_counter.sv
// Sync-relative position counter that measures the period between
// leading edges and checks the sync pulse width.
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int W     = 11,
    parameter int TOTAL = 1056,
    parameter int PULSE = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         lead,
    input  logic         trail,
    input  logic         clr_seen,
    output logic [W-1:0] count,
    output logic [W-1:0] total_meas,
    output logic         total_err,
    output logic         pulse_err
);

    localparam logic [W:0] TOT = (W+1)'(TOTAL);
    localparam logic [W:0] PUL = (W+1)'(PULSE);

    logic       seen;
    logic [W:0] cnt_p1;

    // One extra bit so a saturated count plus one never wraps.
    assign cnt_p1    = {1'b0, count} + (W+1)'(1);
    assign total_err = lead && seen && (cnt_p1 != TOT);
    assign pulse_err = trail && (cnt_p1 != PUL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            total_meas <= '0;
            seen       <= 1'b0;
        end else begin
            if (lead)
                count <= '0;
            else if (inc && !(&count))
                count <= cnt_p1[W-1:0];
            if (lead && seen)
                total_meas <= cnt_p1[W-1:0];
            if (clr_seen)
                seen <= 1'b0;
            else if (lead)
                seen <= 1'b1;
        end
    end

endmodule

// File: rtl/vga_rx.sv
// VGA receiver: recovers line/frame timing, verifies it for a number
// of frames, then emits visible pixels with their coordinates.
module vga_rx
    import vga_pkg::*;
#(
    parameter int H_VIS_AREA_PXL    = 800,
    parameter int H_FRONT_PORCH_PXL = 40,
    parameter int H_SYNC_PULSE_PXL  = 128,
    parameter int H_BACK_PORCH_PXL  = 88,
    parameter int H_NUM_BITS        = 11,
    parameter int V_VIS_AREA_PXL    = 600,
    parameter int V_FRONT_PORCH_PXL = 1,
    parameter int V_SYNC_PULSE_PXL  = 4,
    parameter int V_BACK_PORCH_PXL  = 23,
    parameter int V_NUM_BITS        = 10,
    parameter int CHANNEL_BITS      = 4,
    parameter bit SYNC_ACTIVE       = 1'b1,
    parameter int LOCK_FRAMES       = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [CHANNEL_BITS-1:0] red,
    input  logic [CHANNEL_BITS-1:0] green,
    input  logic [CHANNEL_BITS-1:0] blue,
    input  logic                    h_sync,
    input  logic                    v_sync,
    output logic                    pixel_valid,
    output logic [H_NUM_BITS-1:0]   x,
    output logic [V_NUM_BITS-1:0]   y,
    output logic [CHANNEL_BITS-1:0] pixel_r,
    output logic [CHANNEL_BITS-1:0] pixel_g,
    output logic [CHANNEL_BITS-1:0] pixel_b,
    output logic                    frame_start,
    output logic                    locked,
    output logic                    timing_err,
    output logic [H_NUM_BITS-1:0]   h_total_meas,
    output logic [V_NUM_BITS-1:0]   v_total_meas
);

    localparam int H_TOT = span_total(H_VIS_AREA_PXL, H_FRONT_PORCH_PXL,
                                      H_SYNC_PULSE_PXL, H_BACK_PORCH_PXL);
    localparam int V_TOT = span_total(V_VIS_AREA_PXL, V_FRONT_PORCH_PXL,
                                      V_SYNC_PULSE_PXL, V_BACK_PORCH_PXL);
    localparam int H_BEG = span_start(H_SYNC_PULSE_PXL, H_BACK_PORCH_PXL);
    localparam int V_BEG = span_start(V_SYNC_PULSE_PXL, V_BACK_PORCH_PXL);
    localparam int GW    = $clog2(LOCK_FRAMES + 1);

    localparam logic [H_NUM_BITS:0] H_LO = (H_NUM_BITS+1)'(H_BEG);
    localparam logic [H_NUM_BITS:0] H_HI = (H_NUM_BITS+1)'(H_BEG + H_VIS_AREA_PXL);
    localparam logic [V_NUM_BITS:0] V_LO = (V_NUM_BITS+1)'(V_BEG);
    localparam logic [V_NUM_BITS:0] V_HI = (V_NUM_BITS+1)'(V_BEG + V_VIS_AREA_PXL);
    localparam logic [GW-1:0]       LOCK_CNT = GW'(LOCK_FRAMES);

    logic                    hs_act, vs_act, hs1, vs1;
    logic                    hs_lead, hs_trail, vs_lead, vs_trail;
    logic [CHANNEL_BITS-1:0] r1, g1, b1;
    logic [H_NUM_BITS-1:0]   hcnt;
    logic [V_NUM_BITS-1:0]   vcnt;
    logic                    h_total_err, h_pulse_err;
    logic                    v_total_err, v_pulse_err;
    logic                    h_err, v_err, wd, in_search;
    logic                    h_vis, v_vis, vis;

    lock_state_t   state, state_d;
    logic [GW-1:0] good_cnt, good_d;
    logic          frame_bad, bad_d, err_d;

    assign hs_act   = (h_sync == SYNC_ACTIVE);
    assign vs_act   = (v_sync == SYNC_ACTIVE);
    // Edges compare the port against stage 1, so the counters
    // restart in step with the stage-1 pixel they describe.
    assign hs_lead  = hs_act && !hs1;
    assign hs_trail = !hs_act && hs1;
    assign vs_lead  = vs_act && !vs1;
    assign vs_trail = !vs_act && vs1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hs1 <= 1'b0;
            vs1 <= 1'b0;
            r1  <= '0;
            g1  <= '0;
            b1  <= '0;
        end else begin
            hs1 <= hs_act;
            vs1 <= vs_act;
            r1  <= red;
            g1  <= green;
            b1  <= blue;
        end
    end

    assign in_search = (state == SEARCH);

    vga_sync_counter #(
        .W     (H_NUM_BITS),
        .TOTAL (H_TOT),
        .PULSE (H_SYNC_PULSE_PXL)
    ) u_hcnt (
        .clk        (clk),
        .rst_n      (resetn),
        .inc        (1'b1),
        .lead       (hs_lead),
        .trail      (hs_trail),
        .clr_seen   (in_search),
        .count      (hcnt),
        .total_meas (h_total_meas),
        .total_err  (h_total_err),
        .pulse_err  (h_pulse_err)
    );

    vga_sync_counter #(
        .W     (V_NUM_BITS),
        .TOTAL (V_TOT),
        .PULSE (V_SYNC_PULSE_PXL)
    ) u_vcnt (
        .clk        (clk),
        .rst_n      (resetn),
        .inc        (hs_lead),
        .lead       (vs_lead),
        .trail      (vs_trail),
        .clr_seen   (1'b0),
        .count      (vcnt),
        .total_meas (v_total_meas),
        .total_err  (v_total_err),
        .pulse_err  (v_pulse_err)
    );

    assign h_err = h_total_err || h_pulse_err;
    assign v_err = v_total_err || v_pulse_err;
    assign wd    = &hcnt;

    always_comb begin
        state_d = state;
        good_d  = good_cnt;
        bad_d   = frame_bad;
        err_d   = 1'b0;
        unique case (state)
            SEARCH: begin
                if (vs_lead) begin
                    state_d = VERIFY;
                    good_d  = '0;
                    bad_d   = 1'b0;
                end
            end
            VERIFY: begin
                if (wd) begin
                    state_d = SEARCH;
                end else if (vs_lead) begin
                    bad_d = 1'b0;
                    if (frame_bad || h_err || v_err) begin
                        good_d = '0;
                    end else begin
                        good_d = good_cnt + GW'(1);
                        if (good_d == LOCK_CNT)
                            state_d = LOCKED;
                    end
                end else if (h_err || v_err) begin
                    bad_d = 1'b1;
                end
            end
            LOCKED: begin
                if (h_err || v_err || wd) begin
                    err_d   = 1'b1;
                    state_d = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= SEARCH;
            good_cnt   <= '0;
            frame_bad  <= 1'b0;
            locked     <= 1'b0;
            timing_err <= 1'b0;
        end else begin
            state      <= state_d;
            good_cnt   <= good_d;
            frame_bad  <= bad_d;
            locked     <= (state_d == LOCKED);
            timing_err <= err_d;
        end
    end

    assign h_vis = ({1'b0, hcnt} >= H_LO) && ({1'b0, hcnt} < H_HI);
    assign v_vis = ({1'b0, vcnt} >= V_LO) && ({1'b0, vcnt} < V_HI);
    assign vis   = locked && h_vis && v_vis;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            x           <= '0;
            y           <= '0;
            pixel_r     <= '0;
            pixel_g     <= '0;
            pixel_b     <= '0;
        end else begin
            pixel_valid <= vis;
            frame_start <= vis && (hcnt == H_NUM_BITS'(H_BEG))
                               && (vcnt == V_NUM_BITS'(V_BEG));
            if (vis) begin
                x       <= hcnt - H_NUM_BITS'(H_BEG);
                y       <= vcnt - V_NUM_BITS'(V_BEG);
                pixel_r <= r1;
                pixel_g <= g1;
                pixel_b <= b1;
            end else begin
                x       <= '0;
                y       <= '0;
                pixel_r <= '0;
                pixel_g <= '0;
                pixel_b <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_rx.sv
// Directed bench for vga_rx on a reduced 25x13 raster
// (16x8 visible, h sync 4, v sync 2, starts at column 7 / line 4).
module tb_vga_rx;

    localparam int HT  = 25;
    localparam int HS  = 4;
    localparam int HST = 7;
    localparam int VT  = 13;
    localparam int VS  = 2;
    localparam int VST = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] red = '0, green = '0, blue = '0;
    logic       h_sync = 1'b0, v_sync = 1'b0;
    logic       pixel_valid, frame_start, locked, timing_err;
    logic [5:0] x, h_total_meas;
    logic [4:0] y, v_total_meas;
    logic [3:0] pixel_r, pixel_g, pixel_b;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, drive_cyc = 0, fs_cyc = 0;
    int valid_cnt = 0, fs_cnt = 0, pix_bad = 0;
    int terr_cnt = 0, terr_long = 0, last_x = 0, last_y = 0;
    logic prev_terr = 1'b0;

    always #5 clk = ~clk;

    vga_rx #(
        .H_VIS_AREA_PXL(16), .H_FRONT_PORCH_PXL(2),
        .H_SYNC_PULSE_PXL(4), .H_BACK_PORCH_PXL(3), .H_NUM_BITS(6),
        .V_VIS_AREA_PXL(8), .V_FRONT_PORCH_PXL(1),
        .V_SYNC_PULSE_PXL(2), .V_BACK_PORCH_PXL(2), .V_NUM_BITS(5),
        .CHANNEL_BITS(4), .SYNC_ACTIVE(1'b1), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .resetn(resetn),
        .red(red), .green(green), .blue(blue),
        .h_sync(h_sync), .v_sync(v_sync),
        .pixel_valid(pixel_valid), .x(x), .y(y),
        .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
        .frame_start(frame_start), .locked(locked),
        .timing_err(timing_err),
        .h_total_meas(h_total_meas), .v_total_meas(v_total_meas)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_terr <= timing_err;
        if (timing_err) terr_cnt <= terr_cnt + 1;
        if (timing_err && prev_terr) terr_long <= terr_long + 1;
        if (pixel_valid) begin
            valid_cnt <= valid_cnt + 1;
            last_x <= int'(x);
            last_y <= int'(y);
        end
        if (pixel_valid && (pixel_r !== x[3:0] || pixel_g !== y[3:0]
                            || pixel_b !== 4'hA))
            pix_bad <= pix_bad + 1;
        if (frame_start) begin
            fs_cnt <= fs_cnt + 1;
            fs_cyc <= cyc;
        end
        if (frame_start && (!pixel_valid || x != 6'd0 || y != 5'd0))
            pix_bad <= pix_bad + 1;
    end

    task automatic drive_line(input int len, input int hsw,
                              input bit vs_on, input int line);
        for (int p = 0; p < len; p++) begin
            @(negedge clk);
            if (line == VST && p == HST) drive_cyc = cyc;
            h_sync = (p < hsw);
            v_sync = vs_on;
            red    = 4'(p - HST);
            green  = 4'(line - VST);
            blue   = 4'hA;
        end
    endtask

    task automatic drive_frame(input int l0, input int l1,
                               input int short_l, input int narrow_l);
        for (int l = l0; l <= l1; l++)
            drive_line((l == short_l) ? HT - 1 : HT,
                       (l == narrow_l) ? HS - 1 : HS, (l < VS), l);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            h_sync = 1'b0;
            v_sync = 1'b0;
        end
    endtask

    task automatic relock(input string tag);
        drive_frame(0, VT - 1, -1, -1);
        drive_frame(0, VT - 1, -1, -1);
        n_chk++;
        if (locked !== 1'b0) $display("FAIL %s_early locked=%0b want 0", tag, locked);
        else n_pass++;
        drive_frame(0, 0, -1, -1);
        n_chk++;
        if (locked !== 1'b1) $display("FAIL %s_relock locked=%0b want 1", tag, locked);
        else n_pass++;
        drive_frame(1, VT - 1, -1, -1);
        n_chk++;
        if (h_total_meas !== 6'd25)
            $display("FAIL %s_htot got %0d want 25", tag, h_total_meas);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++;
        if (locked !== 1'b0) $display("FAIL rst_locked got %0b want 0", locked);
        else n_pass++;
        n_chk++;
        if (pixel_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", pixel_valid);
        else n_pass++;
        n_chk++;
        if (h_total_meas !== 6'd0 || v_total_meas !== 5'd0)
            $display("FAIL rst_meas got %0d/%0d want 0/0", h_total_meas, v_total_meas);
        else n_pass++;
        n_chk++;
        if (timing_err !== 1'b0 || frame_start !== 1'b0)
            $display("FAIL rst_pulses got %0b%0b want 00", timing_err, frame_start);
        else n_pass++;
        resetn = 1'b1;
    endtask

    task automatic test_lock();
        drive_frame(0, VT - 1, -1, -1);
        drive_frame(0, VT - 1, -1, -1);
        n_chk++;
        if (locked !== 1'b0) $display("FAIL lock_early got %0b want 0", locked);
        else n_pass++;
        drive_frame(0, 0, -1, -1);
        n_chk++;
        if (locked !== 1'b1) $display("FAIL lock_third got %0b want 1", locked);
        else n_pass++;
        drive_frame(1, VT - 1, -1, -1);
        n_chk++;
        if (h_total_meas !== 6'd25) $display("FAIL lock_htot got %0d want 25", h_total_meas);
        else n_pass++;
        n_chk++;
        if (v_total_meas !== 5'd13) $display("FAIL lock_vtot got %0d want 13", v_total_meas);
        else n_pass++;
        n_chk++;
        if (terr_cnt !== 0) $display("FAIL lock_terr got %0d want 0", terr_cnt);
        else n_pass++;
    endtask

    task automatic test_pixels();
        int v0, f0, b0;
        v0 = valid_cnt; f0 = fs_cnt; b0 = pix_bad;
        drive_frame(0, VT - 1, -1, -1);
        n_chk++;
        if (valid_cnt - v0 != 128) $display("FAIL pix_count got %0d want 128", valid_cnt - v0);
        else n_pass++;
        n_chk++;
        if (fs_cnt - f0 != 1) $display("FAIL pix_fs got %0d want 1", fs_cnt - f0);
        else n_pass++;
        n_chk++;
        if (pix_bad != b0) $display("FAIL pix_data got %0d bad want 0", pix_bad - b0);
        else n_pass++;
        n_chk++;
        if (last_x != 15 || last_y != 7)
            $display("FAIL pix_last got (%0d,%0d) want (15,7)", last_x, last_y);
        else n_pass++;
        n_chk++;
        if (fs_cyc - drive_cyc != 2)
            $display("FAIL pix_latency got %0d want 2", fs_cyc - drive_cyc);
        else n_pass++;
    endtask

    task automatic test_short_line();
        int t0, l0;
        t0 = terr_cnt; l0 = terr_long;
        drive_frame(0, VT - 1, 5, -1);
        n_chk++;
        if (terr_cnt - t0 != 1) $display("FAIL short_terr got %0d want 1", terr_cnt - t0);
        else n_pass++;
        n_chk++;
        if (terr_long != l0) $display("FAIL short_pulse got %0d long want 0", terr_long - l0);
        else n_pass++;
        n_chk++;
        if (locked !== 1'b0) $display("FAIL short_locked got %0b want 0", locked);
        else n_pass++;
        n_chk++;
        if (h_total_meas !== 6'd24) $display("FAIL short_htot got %0d want 24", h_total_meas);
        else n_pass++;
        relock("short");
    endtask

    task automatic test_narrow_hs();
        int t0;
        t0 = terr_cnt;
        drive_frame(0, VT - 1, -1, 3);
        n_chk++;
        if (terr_cnt - t0 != 1) $display("FAIL narrow_terr got %0d want 1", terr_cnt - t0);
        else n_pass++;
        n_chk++;
        if (locked !== 1'b0) $display("FAIL narrow_locked got %0b want 0", locked);
        else n_pass++;
        relock("narrow");
    endtask

    task automatic test_watchdog();
        int t0, v0;
        t0 = terr_cnt;
        drive_frame(0, 5, -1, -1);
        idle(3);
        v0 = valid_cnt;
        idle(70);
        n_chk++;
        if (locked !== 1'b0) $display("FAIL wd_locked got %0b want 0", locked);
        else n_pass++;
        n_chk++;
        if (terr_cnt - t0 != 1) $display("FAIL wd_terr got %0d want 1", terr_cnt - t0);
        else n_pass++;
        n_chk++;
        if (valid_cnt != v0) $display("FAIL wd_valid got %0d want 0", valid_cnt - v0);
        else n_pass++;
        relock("wd");
    endtask

    task automatic test_async_reset();
        drive_frame(0, 8, -1, -1);
        drive_line(12, HS, 1'b0, 9);
        #2;
        n_chk++;
        if (pixel_valid !== 1'b1 || x !== 6'd2)
            $display("FAIL ares_pre got v=%0b x=%0d want v=1 x=2", pixel_valid, x);
        else n_pass++;
        resetn = 1'b0;
        #1;
        n_chk++;
        if (pixel_valid !== 1'b0 || locked !== 1'b0)
            $display("FAIL ares_flags got v=%0b l=%0b want 0 0", pixel_valid, locked);
        else n_pass++;
        n_chk++;
        if (x !== 6'd0 || y !== 5'd0 || pixel_r !== 4'd0 || pixel_b !== 4'd0)
            $display("FAIL ares_pix got x=%0d y=%0d r=%0d b=%0d want 0", x, y, pixel_r, pixel_b);
        else n_pass++;
        n_chk++;
        if (h_total_meas !== 6'd0 || v_total_meas !== 5'd0)
            $display("FAIL ares_meas got %0d/%0d want 0/0", h_total_meas, v_total_meas);
        else n_pass++;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        drive_frame(9, VT - 1, -1, -1);
        n_chk++;
        if (locked !== 1'b0) $display("FAIL ares_post got %0b want 0", locked);
        else n_pass++;
        relock("ares");
    endtask

    initial begin
        test_reset();
        test_lock();
        test_pixels();
        test_short_line();
        test_narrow_hs();
        test_watchdog();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_rx.md
Name: vga_rx

Overview:
- Receiving end of the VGA link; the counterpart of the VGA timing generator.
- Takes h_sync/v_sync and RGB from the same clock domain, recovers line and frame timing, and measures line and frame totals.
- Locks after consecutive correct frames, then emits visible pixels with (x, y) coordinates.
- Used as an on-chip loopback checker for the generator and as the front end of a future frame-capture path.

Parameters:
H_VIS_AREA_PXL, 800, visible pixels per line
H_FRONT_PORCH_PXL, 40, horizontal front porch
H_SYNC_PULSE_PXL, 128, horizontal sync width
H_BACK_PORCH_PXL, 88, horizontal back porch
H_NUM_BITS, 11, horizontal counter width
V_VIS_AREA_PXL, 600, visible lines
V_FRONT_PORCH_PXL, 1, vertical front porch (lines)
V_SYNC_PULSE_PXL, 4, vertical sync width (lines)
V_BACK_PORCH_PXL, 23, vertical back porch (lines)
V_NUM_BITS, 10, vertical counter width
CHANNEL_BITS, 4, bits per colour channel
SYNC_ACTIVE, 1, active level of both syncs
LOCK_FRAMES, 2, consecutive good frames needed to lock (>=1)

Ports:
clk  in  1  pixel clock
resetn  in  1  asynchronous active-low reset
red  in  CHANNEL_BITS  incoming red
green  in  CHANNEL_BITS  incoming green
blue  in  CHANNEL_BITS  incoming blue
h_sync  in  1  incoming horizontal sync
v_sync  in  1  incoming vertical sync
pixel_valid  out  1  visible pixel on pixel_* this cycle
x  out  H_NUM_BITS  visible column, 0..H_VIS_AREA_PXL-1
y  out  V_NUM_BITS  visible row, 0..V_VIS_AREA_PXL-1
pixel_r  out  CHANNEL_BITS  red for the visible pixel
pixel_g  out  CHANNEL_BITS  green for the visible pixel
pixel_b  out  CHANNEL_BITS  blue for the visible pixel
frame_start  out  1  one-cycle pulse with pixel (0,0)
locked  out  1  timing verified
timing_err  out  1  one-cycle pulse on any mismatch while locked
h_total_meas  out  H_NUM_BITS  last measured line length (clocks)
v_total_meas  out  V_NUM_BITS  last measured frame length (lines)

Behaviour:
- Reset and clocking: one clock `clk`; `resetn` is asynchronous and active-low. Every register and output clears to 0 on reset; the FSM resets to SEARCH.
- Derived constants: H_TOTAL=1056, V_TOTAL=628, H_START=H_SYNC+H_BP=216, V_START=V_SYNC+V_BP=27.
- Input stage: all inputs are registered once (stage 1). Leading and trailing sync edges are detected against the previous stage-1 value.
- Horizontal counter: hcnt <= 0 on an hs leading edge, else hcnt+1, saturating at all-ones.
  - On an hs leading edge with h_seen=1: h_total_meas <= hcnt+1. An h error is flagged if this differs from H_TOTAL.
  - On an hs trailing edge: h error if hcnt+1 != H_SYNC_PULSE_PXL.
  - h_seen is set at the first hs leading edge and cleared in SEARCH.
- Vertical counter:
  - On a vs leading edge: v_total_meas <= vcnt+1 (only if v_seen), then vcnt <= 0.
  - Otherwise an hs leading edge increments vcnt, saturating.
  - A vs leading edge coinciding with an hs leading edge makes that line 0.
  - v error if the v_total_meas value differs from V_TOTAL.
- Watchdog: if hcnt saturates (no hsync), treat it as an error and go to SEARCH.
- Lock FSM:
  - SEARCH -> VERIFY on the first vs leading edge; good_cnt=0, frame_bad=0.
  - VERIFY: any h error sets frame_bad. At each vs leading edge:
    - if !frame_bad and the v total is correct, good_cnt++;
    - otherwise good_cnt=0.
    - frame_bad is cleared at each vs leading edge.
    - good_cnt reaching LOCK_FRAMES -> LOCKED, locked=1.
  - LOCKED: any h, v or watchdog error -> timing_err pulse, locked=0, go to SEARCH. The new frame's errors are evaluated only after re-search.
- Output stage (stage 2, registered):
  - pixel_valid = locked && H_START<=hcnt<H_START+H_VIS && V_START<=vcnt<V_START+V_VIS.
  - x = hcnt-H_START, y = vcnt-V_START, and pixel_* = stage-1 RGB, all valid only when pixel_valid. Otherwise x, y and pixel_* hold 0.
  - frame_start = pixel_valid && x==0 && y==0.
  - Latency: 2 clocks from port input to output.
- Width rules: comparisons are done at H_NUM_BITS+1 / V_NUM_BITS+1 bits so that +1 never wraps.

Decomposition:
- Package vga_pkg:
  - derived constants H_TOTAL, V_TOTAL, H_START, V_START;
  - lock FSM state encoding (SEARCH=0, VERIFY=1, LOCKED=2);
  - shared with the generator.
- Sub-module vga_sync_counter, parameterised by width, expected total and expected pulse width; instantiated twice:
  - horizontal instance: increment on clk;
  - vertical instance: increment enable = hs leading edge.
  - Outputs: count, total_meas, total_err, pulse_err.

Test Plan:
- Ideal 1056x628 timing for 3 frames -> locked rises at the 3rd vs leading edge; h_total_meas=1056, v_total_meas=628.
- Locked; drive RGB=(x[3:0], y[3:0], 4'hA) -> pixel (0,0) shows frame_start=1 at hcnt 216+2 cycles; pixel (799,599) is the last pixel_valid; 480000 valid pixels per frame.
- Locked; one line of 1055 clocks -> timing_err one-cycle pulse, locked=0, h_total_meas=1055, relock after 2 good frames.
- Locked; hs pulse 127 wide -> timing_err, locked=0.
- Locked; stop hsync for 2048 cycles -> watchdog drops lock, pixel_valid stays 0.
- resetn pulled low mid-frame -> all outputs 0 immediately (async); after release locked stays 0 until LOCK_FRAMES good frames have been seen.
